// File: rtl/reg_file_cmd_ctrl.sv
// Turns UART byte frames (AA addr data / BB addr) into register-file writes and reads, returning read data to UART TX.
// All outputs registered; read returns one cycle after rf_read_data_valid when TX is free, otherwise waits while tx_busy is high.
module reg_file_cmd_ctrl #(
  parameter int                    DATA_WIDTH          = 8,
  parameter int                    REGISTER_FILE_DEPTH = 16,
  parameter logic [DATA_WIDTH-1:0] WRITE_CMD           = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] READ_CMD            = 8'hBB,
  parameter int                    TIMEOUT_CYCLES      = 1024
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [DATA_WIDTH-1:0]                  rx_data,
  input  logic                                   rx_data_valid,
  input  logic [DATA_WIDTH-1:0]                  rf_read_data,
  input  logic                                   rf_read_data_valid,
  input  logic                                   tx_busy,
  output logic [$clog2(REGISTER_FILE_DEPTH)-1:0] rf_address,
  output logic                                   rf_write_enable,
  output logic [DATA_WIDTH-1:0]                  rf_write_data,
  output logic                                   rf_read_enable,
  output logic [DATA_WIDTH-1:0]                  tx_data,
  output logic                                   tx_data_valid,
  output logic                                   cmd_error,
  output logic                                   busy
);

  localparam int AW = $clog2(REGISTER_FILE_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_WAIT
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] txd_q, txd_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic                  txv_q, txv_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic addr_ok;
  logic expired;

  // Compare in 32 bits so depths beyond the byte range still work.
  assign addr_ok = ({{(32-DATA_WIDTH){1'b0}}, rx_data} < 32'(REGISTER_FILE_DEPTH));
  assign expired = (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    txd_d     = txd_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    txv_d     = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (rx_data_valid) begin
          if (rx_data == WRITE_CMD)     state_d = WR_ADDR;
          else if (rx_data == READ_CMD) state_d = RD_ADDR;
          else                          err_d   = 1'b1;
        end
      end
      WR_ADDR, RD_ADDR: begin
        if (rx_data_valid) begin
          tmo_cnt_d = '0;
          if (!addr_ok) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d  = rx_data[AW-1:0];
            re_d    = (state_q == RD_ADDR);
            state_d = (state_q == RD_ADDR) ? RD_WAIT : WR_DATA;
          end
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      WR_DATA: begin
        if (rx_data_valid) begin
          tmo_cnt_d = '0;
          wdata_d   = rx_data;
          we_d      = 1'b1;
          state_d   = IDLE;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      RD_WAIT: begin
        // A stray byte is flagged but never disturbs the read in flight.
        err_d = rx_data_valid;
        if (rf_read_data_valid) begin
          txd_d = rf_read_data;
          if (!tx_busy) begin
            txv_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = TX_WAIT;
          end
        end
      end
      TX_WAIT: begin
        err_d = rx_data_valid;
        if (!tx_busy) begin
          txv_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tmo_cnt_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      txd_q     <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      txv_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      txd_q     <= txd_d;
      we_q      <= we_d;
      re_q      <= re_d;
      txv_q     <= txv_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign rf_address      = addr_q;
  assign rf_write_enable = we_q;
  assign rf_write_data   = wdata_q;
  assign rf_read_enable  = re_q;
  assign tx_data         = txd_q;
  assign tx_data_valid   = txv_q;
  assign cmd_error       = err_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// Directed bench for reg_file_cmd_ctrl: vector table for single-cycle behaviour,
// hand sequences for TX back-pressure, timeout and mid-frame reset.
module tb_reg_file_cmd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic [7:0] rf_read_data;
  logic       rf_read_data_valid;
  logic       tx_busy;
  logic [3:0] rf_address;
  logic       rf_write_enable;
  logic [7:0] rf_write_data;
  logic       rf_read_enable;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       cmd_error;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rf_read_data(rf_read_data), .rf_read_data_valid(rf_read_data_valid),
    .tx_busy(tx_busy),
    .rf_address(rf_address), .rf_write_enable(rf_write_enable),
    .rf_write_data(rf_write_data), .rf_read_enable(rf_read_enable),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .cmd_error(cmd_error), .busy(busy)
  );

  typedef struct {
    logic       v;   logic [7:0] b;
    logic       rdv; logic [7:0] rd; logic txb;
    logic       we;  logic re; logic [3:0] addr; logic [7:0] wd;
    logic       txv; logic [7:0] txd; logic err; logic busy;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Present inputs for one cycle; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic v, input logic [7:0] b, input logic rdv,
                     input logic [7:0] rd, input logic txb);
    rx_data_valid      = v;
    rx_data            = b;
    rf_read_data_valid = rdv;
    rf_read_data       = rd;
    tx_busy            = txb;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input logic txb);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, txb);
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    //          v  b      rdv rd     txb we re addr  wd     txv txd    err busy
    vecs[0]  = '{1, 8'hAA, 0, 8'h00, 0,  0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 1};
    vecs[1]  = '{1, 8'h05, 0, 8'h00, 0,  0, 0, 4'h5, 8'h00, 0, 8'h00, 0, 1};
    vecs[2]  = '{1, 8'h3C, 0, 8'h00, 0,  1, 0, 4'h5, 8'h3C, 0, 8'h00, 0, 0};
    vecs[3]  = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h5, 8'h3C, 0, 8'h00, 0, 0};
    vecs[4]  = '{1, 8'hBB, 0, 8'h00, 0,  0, 0, 4'h5, 8'h3C, 0, 8'h00, 0, 1};
    vecs[5]  = '{1, 8'h02, 0, 8'h00, 0,  0, 1, 4'h2, 8'h3C, 0, 8'h00, 0, 1};
    vecs[6]  = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 0, 8'h00, 0, 1};
    vecs[7]  = '{0, 8'h00, 1, 8'h01, 0,  0, 0, 4'h2, 8'h3C, 1, 8'h01, 0, 0};
    vecs[8]  = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 0, 8'h01, 0, 0};
    vecs[9]  = '{1, 8'h55, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 0, 8'h01, 1, 0};
    vecs[10] = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 0, 8'h01, 0, 0};
    vecs[11] = '{1, 8'hAA, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 0, 8'h01, 0, 1};
    vecs[12] = '{1, 8'h10, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 0, 8'h01, 1, 0};
    vecs[13] = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 0, 8'h01, 0, 0};
    vecs[14] = '{1, 8'hBB, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 0, 8'h01, 0, 1};
    vecs[15] = '{1, 8'h09, 0, 8'h00, 0,  0, 1, 4'h9, 8'h3C, 0, 8'h01, 0, 1};
    vecs[16] = '{1, 8'h77, 0, 8'h00, 0,  0, 0, 4'h9, 8'h3C, 0, 8'h01, 1, 1};
    vecs[17] = '{0, 8'h00, 1, 8'h5A, 0,  0, 0, 4'h9, 8'h3C, 1, 8'h5A, 0, 0};
    vecs[18] = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h9, 8'h3C, 0, 8'h5A, 0, 0};
    vecs[19] = '{1, 8'hAA, 0, 8'h00, 0,  0, 0, 4'h9, 8'h3C, 0, 8'h5A, 0, 1};
    vecs[20] = '{1, 8'h0F, 0, 8'h00, 0,  0, 0, 4'hF, 8'h3C, 0, 8'h5A, 0, 1};
    vecs[21] = '{1, 8'h11, 0, 8'h00, 0,  1, 0, 4'hF, 8'h11, 0, 8'h5A, 0, 0};
    vecs[22] = '{1, 8'hBB, 0, 8'h00, 0,  0, 0, 4'hF, 8'h11, 0, 8'h5A, 0, 1};
    vecs[23] = '{1, 8'h00, 0, 8'h00, 0,  0, 1, 4'h0, 8'h11, 0, 8'h5A, 0, 1};
    vecs[24] = '{0, 8'h00, 1, 8'h22, 0,  0, 0, 4'h0, 8'h11, 1, 8'h22, 0, 0};
    vecs[25] = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h0, 8'h11, 0, 8'h22, 0, 0};

    reset = 1'b0;
    rx_data_valid = 1'b0; rx_data = '0;
    rf_read_data_valid = 1'b0; rf_read_data = '0; tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we",   int'(rf_write_enable), 0);
    chk("rst_re",   int'(rf_read_enable), 0);
    chk("rst_txv",  int'(tx_data_valid), 0);
    chk("rst_err",  int'(cmd_error), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_addr", int'(rf_address), 0);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 26; i++) begin
      cyc(vecs[i].v, vecs[i].b, vecs[i].rdv, vecs[i].rd, vecs[i].txb);
      chk($sformatf("v%0d_we", i),   int'(rf_write_enable), int'(vecs[i].we));
      chk($sformatf("v%0d_re", i),   int'(rf_read_enable),  int'(vecs[i].re));
      chk($sformatf("v%0d_addr", i), int'(rf_address),      int'(vecs[i].addr));
      chk($sformatf("v%0d_wd", i),   int'(rf_write_data),   int'(vecs[i].wd));
      chk($sformatf("v%0d_txv", i),  int'(tx_data_valid),   int'(vecs[i].txv));
      chk($sformatf("v%0d_txd", i),  int'(tx_data),         int'(vecs[i].txd));
      chk($sformatf("v%0d_err", i),  int'(cmd_error),       int'(vecs[i].err));
      chk($sformatf("v%0d_busy", i), int'(busy),            int'(vecs[i].busy));
    end

    // Read held back by tx_busy
    send(8'hBB);
    send(8'h02);
    chk("txw_re", int'(rf_read_enable), 1);
    chk("txw_addr", int'(rf_address), 2);
    cyc(1'b0, 8'h00, 1'b1, 8'h01, 1'b1);
    chk("txw_ret_txv", int'(tx_data_valid), 0);
    chk("txw_ret_busy", int'(busy), 1);
    for (int i = 0; i < 9; i++) begin
      idle_cyc(1'b1);
      chk($sformatf("txw%0d_txv", i), int'(tx_data_valid), 0);
      chk($sformatf("txw%0d_txd", i), int'(tx_data), 8'h01);
      chk($sformatf("txw%0d_busy", i), int'(busy), 1);
    end
    idle_cyc(1'b0);
    chk("txw_rel_txv", int'(tx_data_valid), 1);
    chk("txw_rel_txd", int'(tx_data), 8'h01);
    chk("txw_rel_busy", int'(busy), 0);
    idle_cyc(1'b0);
    chk("txw_after_txv", int'(tx_data_valid), 0);

    // Timeout: 15 quiet cycles are tolerated, the 16th expires
    send(8'hAA);
    for (int i = 0; i < 15; i++) begin
      idle_cyc(1'b0);
      chk($sformatf("tmo%0d_err", i), int'(cmd_error), 0);
      chk($sformatf("tmo%0d_busy", i), int'(busy), 1);
    end
    idle_cyc(1'b0);
    chk("tmo_exp_err", int'(cmd_error), 1);
    chk("tmo_exp_busy", int'(busy), 0);
    chk("tmo_exp_we", int'(rf_write_enable), 0);
    idle_cyc(1'b0);
    chk("tmo_post_err", int'(cmd_error), 0);

    // Byte on the expiry cycle wins
    send(8'hAA);
    for (int i = 0; i < 15; i++) idle_cyc(1'b0);
    send(8'h03);
    chk("tmo_win_err", int'(cmd_error), 0);
    chk("tmo_win_busy", int'(busy), 1);
    chk("tmo_win_addr", int'(rf_address), 3);
    send(8'h44);
    chk("tmo_win_we", int'(rf_write_enable), 1);
    chk("tmo_win_wd", int'(rf_write_data), 8'h44);

    // Reset in the middle of a frame
    send(8'hAA);
    send(8'h07);
    chk("mid_addr", int'(rf_address), 7);
    rx_data_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mrst_addr", int'(rf_address), 0);
    chk("mrst_wd", int'(rf_write_data), 0);
    chk("mrst_txd", int'(tx_data), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_we", int'(rf_write_enable), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    idle_cyc(1'b0);
    chk("mrel_busy", int'(busy), 0);
    chk("mrel_we", int'(rf_write_enable), 0);
    chk("mrel_err", int'(cmd_error), 0);
    send(8'hAA);
    send(8'h07);
    send(8'h99);
    chk("mre_we", int'(rf_write_enable), 1);
    chk("mre_addr", int'(rf_address), 7);
    chk("mre_wd", int'(rf_write_data), 8'h99);
    begin
      int extra_we = 0;
      for (int i = 0; i < 5; i++) begin
        idle_cyc(1'b0);
        extra_we += int'(rf_write_enable);
      end
      chk("mre_single_we", extra_we, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_cmd_ctrl.md
Name: reg_file_cmd_ctrl

Overview:
- Command controller between the UART receive/transmit datapath and the configuration register file.
- Parses byte frames from UART RX into register-file write and read transactions.
- Returns read data to UART TX.
- Single requester and sequencer for the register file port; it never asserts write and read enables together.

Parameters:
DATA_WIDTH, 8, width of UART bytes and register-file words
REGISTER_FILE_DEPTH, 16, number of register-file entries; address width is $clog2(REGISTER_FILE_DEPTH)
WRITE_CMD, 8'hAA, command byte that opens a write frame
READ_CMD, 8'hBB, command byte that opens a read frame
TIMEOUT_CYCLES, 1024, maximum idle clock cycles allowed between bytes of one frame

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx_data  input  DATA_WIDTH  received UART byte
rx_data_valid  input  1  one-cycle strobe; rx_data is valid
rf_read_data  input  DATA_WIDTH  register-file read data
rf_read_data_valid  input  1  register-file read-data strobe
tx_busy  input  1  UART TX is serialising; high means it cannot accept a byte
rf_address  output  $clog2(REGISTER_FILE_DEPTH)  register-file address
rf_write_enable  output  1  one-cycle write strobe
rf_write_data  output  DATA_WIDTH  register-file write data
rf_read_enable  output  1  one-cycle read strobe
tx_data  output  DATA_WIDTH  byte to transmit
tx_data_valid  output  1  one-cycle transmit strobe
cmd_error  output  1  one-cycle strobe on a malformed or aborted frame
busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: single clock domain. reset low asynchronously forces state IDLE and clears the timeout counter and all outputs to 0.
- Registered outputs: every output is driven from a flop.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_WAIT.
- IDLE:
  - rx_data_valid with rx_data==WRITE_CMD -> WR_ADDR.
  - rx_data_valid with rx_data==READ_CMD -> RD_ADDR.
  - Any other byte -> cmd_error pulse, stay IDLE.
- Address check (WR_ADDR, RD_ADDR): the accepted byte must be < REGISTER_FILE_DEPTH. Otherwise: cmd_error pulse, go IDLE, no register-file access.
- WR_ADDR: valid address byte -> latch it into rf_address, go WR_DATA.
- WR_DATA: on the accepting edge:
  - rf_write_data <= byte, rf_write_enable <= 1, go IDLE.
  - rf_write_enable is high for exactly one cycle.
  - A new command byte arriving during that cycle is accepted normally in IDLE.
- RD_ADDR: valid address byte, on the accepting edge:
  - rf_address <= byte, rf_read_enable <= 1 for one cycle, go RD_WAIT.
- RD_WAIT: on rf_read_data_valid:
  - tx_data <= rf_read_data.
  - tx_busy low: tx_data_valid <= 1 for one cycle, go IDLE.
  - tx_busy high: go TX_WAIT.
- TX_WAIT: hold tx_data. First cycle with tx_busy low -> tx_data_valid one-cycle pulse, go IDLE.
- Read latency, tx idle: address byte strobe at cycle N -> rf_read_enable high in N+1 -> rf_read_data_valid in N+2 -> tx_data_valid in N+3.
- Timeout (WR_ADDR, WR_DATA, RD_ADDR only):
  - Counter clears on entry to these states and on each accepted byte; increments every cycle otherwise.
  - Reaching TIMEOUT_CYCLES-1 with no byte -> cmd_error pulse, go IDLE, no access.
  - A byte arriving in the same cycle as expiry wins: it is accepted and there is no error.
- rx_data_valid in RD_WAIT or TX_WAIT: byte dropped, cmd_error pulse, current read completes unaffected.
- rf_address and rf_write_data hold their last values when idle; rf_address does not change while a strobe is high.
- cmd_error, rf_write_enable, rf_read_enable and tx_data_valid are never high for two consecutive cycles from the same event.
- Reset asserted mid-frame: frame discarded; after release, state is IDLE with no pending strobes.

Test Plan:
- Write frame: bytes AA, 05, 3C -> one-cycle rf_write_enable with rf_address=5, rf_write_data=3C, one cycle after the 3C strobe; cmd_error stays 0.
- Read frame, tx idle: BB, 02; register file returns 01 -> rf_read_enable with rf_address=2 at N+1; tx_data_valid with tx_data=01 at N+3.
- Read with tx_busy high for 10 cycles after the data return -> tx_data=01 held; tx_data_valid pulses on the first cycle tx_busy is low; busy stays high until then.
- Illegal input: byte 55 in IDLE -> cmd_error pulse; frame AA, 10 -> cmd_error, no write; rx byte during RD_WAIT -> cmd_error, read still returns correct data.
- Timeout, with TIMEOUT_CYCLES=16: send AA and then nothing -> cmd_error after 16 cycles, state IDLE. Then AA, 03 with the 03 arriving on the expiry cycle -> no error, state WR_DATA.
- Reset mid-frame: AA, 07, then reset low -> all outputs 0. After release, send AA, 07, 99 -> single write of 99 to address 7.
